// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI CRU bit-bank controller.
package tipi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TI_WR,
        HOST,
        HOST_WAIT
    } arb_state_e;

    localparam logic [3:0] CRU_PREFIX = 4'b0001;
    localparam int unsigned BIT_EN  = 0;
    localparam int unsigned BIT_RST = 1;

    function automatic logic cru_hit(
        input logic [15:1] a,
        input logic [3:0]  base
    );
        return (a[15:12] == CRU_PREFIX)
            && (a[11:8] == base)
            && (a[7:3] == 5'd0);
    endfunction

endpackage

// File: rtl/tipi_sync2.sv
// Parameterised-width two-flop synchroniser, cleared by async reset.
module tipi_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/tipi_cru_ctrl.sv
// TIPI CRU bit bank: TI/host write arbitration, CRU read-back
// and the timed reset pulse, all in the clk domain.
module tipi_cru_ctrl
    import tipi_pkg::*;
#(
    parameter logic [3:0]  CRU_BASE     = 4'h2,
    parameter logic [15:0] PULSE_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ti_cru_clk,
    input  logic        ti_memen,
    input  logic [15:1] addr,
    input  logic        ti_cru_out,
    output logic        ti_cru_in,
    output logic        ti_cru_in_oe,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [1:0]  host_bit,
    input  logic        host_wdata,
    output logic        host_ack,
    output logic        host_rdata,
    output logic [3:0]  bits,
    output logic        rst_pulse
);

    logic        stb_s;
    logic        stb_q;
    logic [16:0] bus_s;
    logic [15:1] addr_s;
    logic        data_s;
    logic        memen_s;
    logic        hit_s;
    logic [1:0]  idx_s;
    logic        ti_ev;

    tipi_sync2 #(.W(1)) u_sync_stb (
        .clk   (clk),
        .reset (reset),
        .d_i   (ti_cru_clk),
        .q_o   (stb_s)
    );

    tipi_sync2 #(.W(17)) u_sync_bus (
        .clk   (clk),
        .reset (reset),
        .d_i   ({ti_memen, ti_cru_out, addr}),
        .q_o   (bus_s)
    );

    assign addr_s  = bus_s[14:0];
    assign data_s  = bus_s[15];
    assign memen_s = bus_s[16];
    assign hit_s   = cru_hit(addr_s, CRU_BASE);
    assign idx_s   = addr_s[2:1];
    assign ti_ev   = stb_s & ~stb_q & hit_s;

    arb_state_e  state_q, state_d;
    logic [3:0]  bits_q, bits_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic        wr_dat_q, wr_dat_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic        pend_dat_q, pend_dat_d;
    logic        ack_q, ack_d;
    logic        rdata_q, rdata_d;
    logic        oe_q, oe_d;
    logic        cin_q, cin_d;
    logic        b1_q;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        wr_idx_d   = wr_idx_q;
        wr_dat_d   = wr_dat_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        pend_dat_d = pend_dat_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (ti_ev) begin
                    wr_idx_d = idx_s;
                    wr_dat_d = data_s;
                    pend_d   = 1'b0;
                    state_d  = TI_WR;
                end else if (pend_q) begin
                    wr_idx_d = pend_idx_q;
                    wr_dat_d = pend_dat_q;
                    pend_d   = 1'b0;
                    state_d  = TI_WR;
                end else if (host_req) begin
                    state_d = HOST;
                end
            end
            TI_WR: begin
                bits_d[wr_idx_q] = wr_dat_q;
                state_d          = IDLE;
            end
            HOST: begin
                if (host_we) begin
                    bits_d[host_bit] = host_wdata;
                end
                rdata_d = bits_q[host_bit];
                ack_d   = 1'b1;
                state_d = HOST_WAIT;
            end
            HOST_WAIT: begin
                if (!host_req) begin
                    state_d = IDLE;
                end
            end
        endcase

        // TI writes seen while busy are parked; a later one replaces it
        if (ti_ev && (state_q != IDLE)) begin
            pend_d     = 1'b1;
            pend_idx_d = idx_s;
            pend_dat_d = data_s;
        end
    end

    always_comb begin
        oe_d  = memen_s & hit_s;
        cin_d = oe_d & bits_q[idx_s];
        cnt_d = cnt_q;
        if (bits_q[BIT_RST] && !b1_q) begin
            cnt_d = PULSE_CYCLES;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_q      <= 1'b0;
            state_q    <= IDLE;
            bits_q     <= 4'b0;
            wr_idx_q   <= 2'd0;
            wr_dat_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            pend_dat_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 1'b0;
            oe_q       <= 1'b0;
            cin_q      <= 1'b0;
            b1_q       <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            stb_q      <= stb_s;
            state_q    <= state_d;
            bits_q     <= bits_d;
            wr_idx_q   <= wr_idx_d;
            wr_dat_q   <= wr_dat_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pend_dat_q <= pend_dat_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
            cin_q      <= cin_d;
            b1_q       <= bits_q[BIT_RST];
            cnt_q      <= cnt_d;
        end
    end

    assign bits         = bits_q;
    assign host_ack     = ack_q;
    assign host_rdata   = rdata_q;
    assign ti_cru_in_oe = oe_q;
    assign ti_cru_in    = cin_q;
    assign rst_pulse    = (cnt_q != 16'd0);

endmodule
